// File: rtl/st_demultiplexer_2.sv
// 1-to-2 Avalon-ST demultiplexer with a small FIFO per output; the channel is locked for a whole packet.
// Define ST_DEMUX_STATS_EN to add the stat_pkt0/stat_pkt1/stat_err counters.
module st_demultiplexer_2 #(
    parameter  int DWIDTH = 8,
    parameter  int DEPTH  = 16,
    localparam int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_startofpacket,
    input  logic              in_endofpacket,
    input  logic              in_channel,
    output logic [DWIDTH-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic              out0_startofpacket,
    output logic              out0_endofpacket,
    output logic [DWIDTH-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic              out1_startofpacket,
    output logic              out1_endofpacket,
    output logic [AWIDTH:0]   out0_cnt,
    output logic [AWIDTH:0]   out1_cnt,
    output logic              err_nosop
`ifdef ST_DEMUX_STATS_EN
    ,
    output logic [31:0]       stat_pkt0,
    output logic [31:0]       stat_pkt1,
    output logic [31:0]       stat_err
`endif
);

    localparam int              EWIDTH   = DWIDTH + 2;
    localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH + 1)'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic              tgt;
    logic              accept;
    logic [1:0]        full;
    logic [1:0]        push;
    logic [1:0]        pop;
    logic [1:0]        out_ready;

    logic [EWIDTH-1:0] fifo_mem [2][DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q [2];
    logic [AWIDTH-1:0] wr_ptr_d [2];
    logic [AWIDTH-1:0] rd_ptr_q [2];
    logic [AWIDTH-1:0] rd_ptr_d [2];
    logic [AWIDTH:0]   cnt_q    [2];
    logic [AWIDTH:0]   cnt_d    [2];
    logic [EWIDTH-1:0] head     [2];

    assign out_ready = {out1_ready, out0_ready};

    // NOTE: every signal gets a default at the top of an always_comb so no path infers a latch.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            full[i] = (cnt_q[i] == FULL_CNT);
        end
        tgt       = (state_q == IN_PKT) ? lock_q : in_channel;
        accept    = in_valid && in_ready;
        push      = 2'b00;
        push[tgt] = accept;
    end

    // FSM next state: only an accepted beat can move it.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_startofpacket && !in_endofpacket) begin
                        state_d = IN_PKT;
                        lock_d  = in_channel;
                    end
                end
                IN_PKT: begin
                    if (in_endofpacket) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs. A full target stalls the input even while it is being popped.
    always_comb begin
        in_ready = reset_n && !full[tgt];
        err_d    = accept && (state_q == IDLE) && !in_startofpacket;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            pop[i]      = out_ready[i] && (cnt_q[i] != '0);
            wr_ptr_d[i] = wr_ptr_q[i] + AWIDTH'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + AWIDTH'(pop[i]);
            cnt_d[i]    = cnt_q[i] + (AWIDTH + 1)'(push[i]) - (AWIDTH + 1)'(pop[i]);
            head[i]     = fifo_mem[i][rd_ptr_q[i]];
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            for (int i = 0; i < 2; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers and counts alone decide which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr_q[i]] <= {in_startofpacket, in_endofpacket, in_data};
            end
        end
    end

    assign out0_valid = (cnt_q[0] != '0);
    assign out1_valid = (cnt_q[1] != '0);
    assign {out0_startofpacket, out0_endofpacket, out0_data} = head[0];
    assign {out1_startofpacket, out1_endofpacket, out1_data} = head[1];
    assign out0_cnt   = cnt_q[0];
    assign out1_cnt   = cnt_q[1];
    assign err_nosop  = err_q;

`ifdef ST_DEMUX_STATS_EN
    logic [31:0] stat_pkt0_q, stat_pkt0_d;
    logic [31:0] stat_pkt1_q, stat_pkt1_d;
    logic [31:0] stat_err_q,  stat_err_d;

    // Packets are counted as their eop beat leaves each output.
    always_comb begin
        stat_pkt0_d = stat_pkt0_q + 32'(pop[0] && head[0][EWIDTH-2]);
        stat_pkt1_d = stat_pkt1_q + 32'(pop[1] && head[1][EWIDTH-2]);
        stat_err_d  = stat_err_q + 32'(err_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_pkt0_q <= '0;
            stat_pkt1_q <= '0;
            stat_err_q  <= '0;
        end else begin
            stat_pkt0_q <= stat_pkt0_d;
            stat_pkt1_q <= stat_pkt1_d;
            stat_err_q  <= stat_err_d;
        end
    end

    assign stat_pkt0 = stat_pkt0_q;
    assign stat_pkt1 = stat_pkt1_q;
    assign stat_err  = stat_err_q;
`endif

endmodule
